// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline-register sequencing for a 5-stage ARM core. Tracks EX
//            and MEM destinations, detects RAW hazards with or without
//            forwarding, freezes on slow memory, counts stalls and flags
//            memory time-outs.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_use_rn,
  input  logic             id_two_src,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  input  logic             fwd_en,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [WC_W-1:0] wait_cnt, wait_nx;
  logic            timeout_nx;

  // Scoreboard entries shadowing ID/EX and EX/MEM
  logic       ex_valid, ex_wb, ex_mem_r;
  logic [3:0] ex_dest;
  logic       mem_valid, mem_wb, mem_mem_r;
  logic [3:0] mem_dest;

  logic match_ex, match_mem, hazard;

  // RAW detection against the two in-flight producers
  always_comb begin
    match_ex  = ex_valid & ex_wb &
                ((id_use_rn & (id_src1 == ex_dest)) | (id_two_src & (id_src2 == ex_dest)));
    match_mem = mem_valid & mem_wb &
                ((id_use_rn & (id_src1 == mem_dest)) | (id_two_src & (id_src2 == mem_dest)));
    // With forwarding only a load in EX cannot be bypassed in time
    hazard    = id_valid & (fwd_en ? (match_ex & ex_mem_r) : (match_ex | match_mem));
  end

  // Pipeline control; everything is forced low while rst is held so that
  // freezes and flushes drop without waiting for a clock edge
  always_comb begin
    freeze_pipe  = ~rst & mem_req & ~mem_ready;
    flush_if_id  = ~rst & ex_branch_taken & ~freeze_pipe;
    bubble_id_ex = ~rst & ~freeze_pipe & (ex_branch_taken | hazard);
    freeze_if    = ~rst & (freeze_pipe | (hazard & ~ex_branch_taken));
  end

  // Scoreboard advances with the back end; a bubble enters as invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_dest   <= 4'd0;
      ex_wb     <= 1'b0;
      ex_mem_r  <= 1'b0;
      mem_valid <= 1'b0;
      mem_dest  <= 4'd0;
      mem_wb    <= 1'b0;
      mem_mem_r <= 1'b0;
    end else if (!freeze_pipe) begin
      mem_valid <= ex_valid;
      mem_dest  <= ex_dest;
      mem_wb    <= ex_wb;
      mem_mem_r <= ex_mem_r;
      if (bubble_id_ex) begin
        ex_valid <= 1'b0;
        ex_dest  <= 4'd0;
        ex_wb    <= 1'b0;
        ex_mem_r <= 1'b0;
      end else begin
        ex_valid <= id_valid;
        ex_dest  <= id_dest;
        ex_wb    <= id_wb_en;
        ex_mem_r <= id_mem_r_en;
      end
    end
  end

  // Memory wait FSM state, wait counter and sticky time-out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      mem_timeout <= timeout_nx;
    end
  end

  // Next-state logic for the memory wait FSM
  always_comb begin
    state_nx   = state;
    wait_nx    = wait_cnt;
    timeout_nx = mem_timeout;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nx = MEM_WAIT;
          wait_nx  = '0;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt == WAIT_MAX) begin
          timeout_nx = 1'b1;
        end
        if (mem_ready || !mem_req) begin
          state_nx = RUN;
          wait_nx  = '0;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_nx = wait_cnt + WC_W'(1);
        end
      end
      default: begin
        state_nx = RUN;
        wait_nx  = '0;
      end
    endcase
  end

  // Saturating count of cycles in which fetch is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (freeze_if && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed scenarios plus randomized traffic for pipe_hazard_ctrl,
//            checked against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_valid = 1'b0, id_use_rn = 1'b0, id_two_src = 1'b0;
  logic [3:0]       id_src1 = 4'd0, id_src2 = 4'd0, id_dest = 4'd0;
  logic             id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic             fwd_en = 1'b0, ex_branch_taken = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0;
  logic             freeze_if, flush_if_id, bubble_id_ex, freeze_pipe, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_use_rn(id_use_rn), .id_two_src(id_two_src),
    .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .fwd_en(fwd_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .freeze_pipe(freeze_pipe), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instructions sitting in EX and MEM, plus counters
  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       wb;
    logic       mr;
  } instr_t;

  instr_t m_ex, m_mem;
  int     m_frozen_run;  // consecutive edges the back end stayed frozen
  bit     m_to;
  int     m_stall;
  bit     e_fp, e_fl, e_bub, e_fi;
  int     total = 0;
  int     bad   = 0;

  function automatic bit reads_from(instr_t p);
    return p.v && p.wb && ((id_use_rn && id_src1 == p.d) || (id_two_src && id_src2 == p.d));
  endfunction

  task automatic predict();
    bit hz;
    if (fwd_en) hz = id_valid && reads_from(m_ex) && m_ex.mr;
    else        hz = id_valid && (reads_from(m_ex) || reads_from(m_mem));
    e_fp  = !rst && mem_req && !mem_ready;
    e_fl  = !rst && ex_branch_taken && !e_fp;
    e_bub = !rst && !e_fp && (ex_branch_taken || hz);
    e_fi  = !rst && (e_fp || (hz && !ex_branch_taken));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mcheck(input string tag);
    predict();
    chk({tag, ":freeze_if"},    32'(freeze_if),    32'(e_fi));
    chk({tag, ":flush_if_id"},  32'(flush_if_id),  32'(e_fl));
    chk({tag, ":bubble_id_ex"}, 32'(bubble_id_ex), 32'(e_bub));
    chk({tag, ":freeze_pipe"},  32'(freeze_pipe),  32'(e_fp));
    chk({tag, ":mem_timeout"},  32'(mem_timeout),  32'(m_to));
    chk({tag, ":stall_cnt"},    32'(stall_cnt),    32'(m_stall));
  endtask

  // Check, take one clock edge, advance the model; starts and ends at edge+1
  task automatic cycle(input string tag);
    #2;
    mcheck(tag);
    @(posedge clk);
    if (m_frozen_run >= TIMEOUT) m_to = 1'b1;
    m_frozen_run = e_fp ? m_frozen_run + 1 : 0;
    if (e_fi && m_stall < SAT) m_stall++;
    if (!e_fp) begin
      m_mem = m_ex;
      m_ex  = e_bub ? instr_t'(0) : instr_t'({id_valid, id_dest, id_wb_en, id_mem_r_en});
    end
    #1;
  endtask

  // Reset asserted between edges so its asynchronous effect is observed
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_ex = '0; m_mem = '0; m_frozen_run = 0; m_to = 1'b0; m_stall = 0;
    mcheck(tag);
    chk({tag, ":stall_zero"}, 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic rn, input logic two, input logic [3:0] s1,
                        input logic [3:0] s2, input logic wb, input logic mr, input logic [3:0] d);
    id_valid = v; id_use_rn = rn; id_two_src = two; id_src1 = s1; id_src2 = s2;
    id_wb_en = wb; id_mem_r_en = mr; id_dest = d;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state: everything low
    do_reset("reset");

    // No forwarding: ADD R3 then SUB reading R3 stalls for two cycles
    fwd_en = 1'b0;
    set_id(1, 1, 1, 1, 2, 1, 0, 3); cycle("t1_add");
    set_id(1, 1, 0, 3, 0, 1, 0, 4);
    #1; chk("t1_stall_ex_fi", 32'(freeze_if), 32'd1); chk("t1_stall_ex_bub", 32'(bubble_id_ex), 32'd1);
    cycle("t1_c1");
    #1; chk("t1_stall_mem_fi", 32'(freeze_if), 32'd1);
    cycle("t1_c2");
    #1; chk("t1_release_fi", 32'(freeze_if), 32'd0); chk("t1_stall_cnt", 32'(stall_cnt), 32'd2);
    cycle("t1_c3");

    // Forwarding: ALU result needs no stall, load-use costs one cycle
    do_reset("t2_rst");
    fwd_en = 1'b1;
    set_id(1, 1, 1, 1, 2, 1, 0, 3); cycle("t2_add");
    set_id(1, 1, 0, 3, 0, 1, 0, 4);
    #1; chk("t2_fwd_fi", 32'(freeze_if), 32'd0);
    cycle("t2_sub");
    set_id(1, 1, 0, 1, 0, 1, 1, 5); cycle("t2_ldr");
    set_id(1, 0, 1, 0, 5, 1, 0, 6);
    #1; chk("t2_lu_fi", 32'(freeze_if), 32'd1); chk("t2_lu_bub", 32'(bubble_id_ex), 32'd1);
    cycle("t2_use1");
    #1; chk("t2_lu_done", 32'(freeze_if), 32'd0);
    cycle("t2_use2");

    // Branch beats hazard
    do_reset("t3_rst");
    fwd_en = 1'b0;
    set_id(1, 1, 1, 1, 2, 1, 0, 3); cycle("t3_add");
    set_id(1, 1, 0, 3, 0, 1, 0, 4); ex_branch_taken = 1'b1;
    #1; chk("t3_flush", 32'(flush_if_id), 32'd1); chk("t3_bub", 32'(bubble_id_ex), 32'd1);
    chk("t3_fi", 32'(freeze_if), 32'd0);
    cycle("t3_br");
    ex_branch_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("t3_stall_cnt", 32'(stall_cnt), 32'd0);
    cycle("t3_after");

    // Memory freeze holds the scoreboard and beats the branch
    do_reset("t4_rst");
    set_id(1, 1, 1, 1, 2, 1, 0, 7); cycle("t4_add");
    set_id(1, 1, 0, 7, 0, 1, 0, 8);
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex_branch_taken = (i >= 3);
      #1; chk("t4_fp", 32'(freeze_pipe), 32'd1); chk("t4_no_flush", 32'(flush_if_id), 32'd0);
      chk("t4_no_bub", 32'(bubble_id_ex), 32'd0);
      cycle("t4_frz");
    end
    mem_ready = 1'b1; ex_branch_taken = 1'b0;
    #1; chk("t4_fp_off", 32'(freeze_pipe), 32'd0); chk("t4_sb_held", 32'(bubble_id_ex), 32'd1);
    cycle("t4_rel");
    mem_req = 1'b0; mem_ready = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("t4_idle");

    // Time-out after TIMEOUT cycles in MEM_WAIT, sticky until reset
    do_reset("t5_rst");
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) cycle("t5_wait");
    #1; chk("t5_not_yet", 32'(mem_timeout), 32'd0);
    cycle("t5_wait_last");
    #1; chk("t5_timeout", 32'(mem_timeout), 32'd1);
    mem_ready = 1'b1;
    cycle("t5_ready");
    #1; chk("t5_sticky", 32'(mem_timeout), 32'd1);
    mem_req = 1'b0; mem_ready = 1'b0;
    cycle("t5_idle");

    // Reset in the middle of a freeze with a hazard and branch pending
    do_reset("t6_pre");
    set_id(1, 1, 1, 1, 2, 1, 0, 3); cycle("t6_add");
    set_id(1, 1, 0, 3, 0, 1, 0, 4); mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    cycle("t6_frz");
    do_reset("t6_rst");
    mem_req = 1'b0; ex_branch_taken = 1'b0;
    cycle("t6_after");

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) fwd_en = $urandom_range(0, 1);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)));
      ex_branch_taken = $urandom_range(0, 9) == 0;
      mem_req   = $urandom_range(0, 2) == 0;
      mem_ready = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
